// File: rtl/upcnt_sched_pkg.sv
// upcnt_pkg: shared definitions for the upcnt_sched slot scheduler.
//   state_e   - FSM state encoding (IDLE/RUN/DONE)
//   UPBND_DEF - default maximum count value
//   cw_f()    - counter width needed to hold 0..UPBND
package upcnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int UPBND_DEF = 15;

    function automatic int cw_f(input int upbnd);
        return (upbnd < 1) ? 1 : $clog2(upbnd + 1);
    endfunction

endpackage

// File: rtl/upcnt_sched_if.sv
// upcnt_sched_if: request/grant bundle between clients and the scheduler.
//   i_req  [NREQ]     level request per client, held until done or withdrawn
//   i_len  [NREQ*CW]  requested final count, field k at [k*CW +: CW]
//   o_gnt  [NREQ]     one-hot grant, high for the whole RUN phase
//   o_done [NREQ]     one-cycle pulse on normal completion
//   o_cnt  [CW]       current counter value
//   o_busy            high while a slot is running or completing
// master = client side, slave = scheduler side.
interface upcnt_sched_if
    import upcnt_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int UPBND = UPBND_DEF
) ();
    localparam int CW = cw_f(UPBND);

    logic [NREQ-1:0]    i_req;
    logic [NREQ*CW-1:0] i_len;
    logic [NREQ-1:0]    o_gnt;
    logic [NREQ-1:0]    o_done;
    logic [CW-1:0]      o_cnt;
    logic               o_busy;

    modport master (output i_req, i_len, input o_gnt, o_done, o_cnt, o_busy);
    modport slave  (input i_req, i_len, output o_gnt, o_done, o_cnt, o_busy);
endinterface

// File: rtl/upcnt_sched_en.sv
// upcnt_en: shared up-counter for the slot scheduler.
//   i_clk  - clock, rising edge
//   i_rstn - asynchronous active-low reset (counter -> 0)
//   i_clr  - synchronous clear, wins over i_en
//   i_en   - count up by one, saturating at UPBND
//   o_cnt  - current count
module upcnt_en #(
    parameter int UPBND = 15,
    parameter int CW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (int'(cnt_q) < UPBND)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
endmodule

// File: rtl/upcnt_sched.sv
// upcnt_sched: shares one bounded up-counter among NREQ requesters.
// In IDLE an arbiter picks a requester, latches its clamped length, and the
// FSM runs the counter 0..len in RUN (grant high), pulses done for one cycle
// in DONE, then returns to IDLE. Dropping the granted request in RUN aborts
// the slot without a done pulse.
//   i_clk  - clock, rising edge
//   i_rstn - asynchronous active-low reset
//   bus    - upcnt_sched_if.slave (i_req, i_len in; o_gnt, o_done, o_cnt,
//            o_busy out; all outputs registered)
// Build option: UPCNT_SCHED_RR_EN selects round-robin arbitration (pointer
// holds last winner, reset to NREQ-1); otherwise fixed priority, lowest
// index wins.
module upcnt_sched
    import upcnt_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int UPBND = UPBND_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    upcnt_sched_if.slave  bus
);
    localparam int CW = cw_f(UPBND);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   cnt;
    logic            cnt_clr, cnt_en;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [CW-1:0]   sel_len, win_len;

`ifdef UPCNT_SCHED_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    int              dist, best_d;
`endif

    // ---------------- arbiter ----------------
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef UPCNT_SCHED_RR_EN
        // Distance from ptr+1 (mod NREQ); the nearest requester wins.
        dist   = 0;
        best_d = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            dist = (j + NREQ - 1 - int'(ptr_q)) % NREQ;
            if (bus.i_req[j] && (dist < best_d)) begin
                best_d  = dist;
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
`else
        // Descending scan so the lowest requesting index is the last write.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (bus.i_req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
`endif
        sel_len = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win_idx == IW'(j)) sel_len = bus.i_len[j*CW +: CW];
        end
        // Clamp keeps the counter inside 0..UPBND, so it can never wrap.
        win_len = (int'(sel_len) > UPBND) ? CW'(UPBND) : sel_len;
        win_oh  = NREQ'(1) << win_idx;
    end

`ifdef UPCNT_SCHED_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == IDLE) && win_vld) ptr_d = win_idx;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) ptr_q <= IW'(NREQ - 1);
        else         ptr_q <= ptr_d;
    end
`endif

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        len_d   = len_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (win_vld) begin
                    state_d = RUN;
                    gnt_d   = win_oh;
                    len_d   = win_len;
                end
            end
            RUN: begin
                // Abort is checked first so it beats completion.
                if (~|(bus.i_req & gnt_q)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_clr = 1'b1;
                end else if (cnt == len_q) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                // Counter holds len_q during DONE, cleared on the way out.
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            len_q   <= len_d;
        end
    end

    upcnt_en #(
        .UPBND (UPBND),
        .CW    (CW)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (cnt_clr),
        .i_en   (cnt_en),
        .o_cnt  (cnt)
    );

    assign bus.o_gnt  = gnt_q;
    assign bus.o_done = done_q;
    assign bus.o_cnt  = cnt;
    assign bus.o_busy = (state_q != IDLE);
endmodule
